// File: rtl/cpu8_pkg.sv
// ---------------------------------------------------------------------------
// cpu8_pkg
//   Constants and types shared by the 8-bit CPU, its instruction memory and
//   the instruction-memory loader.
//   - ADDR_W / INSN_W / OPC_W : instruction address, word and opcode widths
//   - INSN_NOP                : all-zero instruction fed to a stalled CPU
//   - opcode_t                : opcode field values
//   - ld_state_t              : loader FSM encoding, visible to benches by name
// ---------------------------------------------------------------------------
package cpu8_pkg;

  localparam int ADDR_W = 8;
  localparam int INSN_W = 13;
  localparam int OPC_W  = INSN_W - 8;

  localparam logic [INSN_W-1:0] INSN_NOP = 13'h0000;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 5'h00,
    OP_LDI = 5'h01,
    OP_ADD = 5'h02,
    OP_SUB = 5'h03,
    OP_AND = 5'h04,
    OP_OR  = 5'h05,
    OP_XOR = 5'h06,
    OP_LD  = 5'h08,
    OP_ST  = 5'h09,
    OP_JMP = 5'h10,
    OP_JZ  = 5'h11,
    OP_HLT = 5'h18
  } opcode_t;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    GET_LEN = 3'd1,
    GET_HI  = 3'd2,
    GET_LO  = 3'd3,
    WRITE   = 3'd4
  } ld_state_t;

  // Instruction word from the two stream bytes; high-byte bits above the
  // opcode field are dropped.
  function automatic logic [INSN_W-1:0] pack_insn(input logic [7:0] hi,
                                                  input logic [7:0] lo);
    return {hi[OPC_W-1:0], lo};
  endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl_if
//   Host/boot link to the instruction-memory loader.
//   master : host side   (drives ld_start, ld_abort, ld_valid, ld_data)
//   slave  : loader side (drives ld_ready, ld_done, ld_err, words_loaded)
//   A byte moves on a rising clk edge where ld_valid && ld_ready.
// ---------------------------------------------------------------------------
interface imem_load_ctrl_if;
  import cpu8_pkg::*;

  logic              ld_start;
  logic              ld_abort;
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              ld_err;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output ld_start, ld_abort, ld_valid, ld_data,
    input  ld_ready, ld_done, ld_err, words_loaded
  );

  modport slave (
    input  ld_start, ld_abort, ld_valid, ld_data,
    output ld_ready, ld_done, ld_err, words_loaded
  );

endinterface

// File: rtl/imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl
//   Owns the write port and shares the read port of the 256x13 instruction
//   memory. In RUN the CPU fetch address passes straight to the memory; a
//   load request stalls the CPU and writes a program received as a length
//   byte (N = words-1) followed by {hi,lo} byte pairs per word.
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   ld (slave)         host byte stream, abort and load status
//   cpu_addr/cpu_insn  fetch address in, instruction out (NOP while stalled)
//   cpu_stall          CPU must hold its PC
//   mem_raddr/rdata    memory read port (combinational read)
//   mem_we/waddr/wdata memory write port
// ---------------------------------------------------------------------------
module imem_load_ctrl
  import cpu8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  imem_load_ctrl_if.slave      ld,
  input  logic [ADDR_W-1:0]    cpu_addr,
  output logic [INSN_W-1:0]    cpu_insn,
  output logic                 cpu_stall,
  output logic [ADDR_W-1:0]    mem_raddr,
  input  logic [INSN_W-1:0]    mem_rdata,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_waddr,
  output logic [INSN_W-1:0]    mem_wdata
);

  ld_state_t state, state_nxt;

  logic [ADDR_W-1:0] cnt, last;
  logic [OPC_W-1:0]  hi_opc;

  logic              ready_q, stall_q, we_q, done_q, err_q;
  logic              ready_d, stall_d, we_d, done_d, err_d;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [INSN_W-1:0] wdata_q;

  logic accept, abort_act, start_acc, write_fire, is_last;

  assign accept     = ld.ld_valid && ready_q;
  assign abort_act  = ld.ld_abort && (state != RUN);
  assign start_acc  = ld.ld_start && (state == RUN);
  // An abort landing on the WRITE cycle cancels that word.
  assign write_fire = (state == WRITE) && !ld.ld_abort;
  assign is_last    = (cnt == last);

  // ---- state register ----------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // ---- next-state logic --------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    if (abort_act) begin
      state_nxt = RUN;
    end else begin
      unique case (state)
        RUN:     if (ld.ld_start) state_nxt = GET_LEN;
        GET_LEN: if (accept)      state_nxt = GET_HI;
        GET_HI:  if (accept)      state_nxt = GET_LO;
        GET_LO:  if (accept)      state_nxt = WRITE;
        WRITE:   state_nxt = is_last ? RUN : GET_HI;
        default: state_nxt = RUN;
      endcase
    end
  end

  // ---- output logic (next values of the registered outputs) --------------
  always_comb begin
    ready_d = (state_nxt == GET_LEN) || (state_nxt == GET_HI) ||
              (state_nxt == GET_LO);
    stall_d = (state_nxt != RUN);
    we_d    = (state_nxt == WRITE);
    done_d  = write_fire && is_last;
    err_d   = err_q;
    if (start_acc) err_d = 1'b0;
    // Stray bits above the opcode field flag the load but the word is kept.
    if ((state == GET_HI) && accept && (ld.ld_data[7:OPC_W] != '0)) err_d = 1'b1;
    if (abort_act) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      stall_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      stall_q <= stall_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // ---- datapath: length, word counter, high byte, write port -------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= '0;
      cnt     <= '0;
      hi_opc  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      words_q <= '0;
    end else begin
      if (start_acc) words_q <= '0;
      if (accept && !abort_act) begin
        unique case (state)
          GET_LEN: begin
            last <= ld.ld_data;
            cnt  <= '0;
          end
          GET_HI:  hi_opc <= ld.ld_data[OPC_W-1:0];
          GET_LO: begin
            waddr_q <= cnt;
            wdata_q <= pack_insn({3'b000, hi_opc}, ld.ld_data);
          end
          default: ;
        endcase
      end
      if (write_fire) begin
        words_q <= words_q + 1'b1;
        // cnt stops at last, so a 256-word load never wraps back to 0.
        if (!is_last) cnt <= cnt + 1'b1;
      end
    end
  end

  // ---- outputs -----------------------------------------------------------
  assign mem_raddr       = cpu_addr;
  assign cpu_insn        = stall_q ? INSN_NOP : mem_rdata;
  assign cpu_stall       = stall_q;
  assign mem_we          = we_q && !ld.ld_abort;
  assign mem_waddr       = waddr_q;
  assign mem_wdata       = wdata_q;
  assign ld.ld_ready     = ready_q;
  assign ld.ld_done      = done_q;
  assign ld.ld_err       = err_q;
  assign ld.words_loaded = words_q;

endmodule
